// File: rtl/dcache_direct_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
package dcache_direct_pkg;

    localparam int unsigned TAG_W      = 3;
    localparam int unsigned INDEX_W    = 3;
    localparam int unsigned OFFSET_W   = 2;
    localparam int unsigned BLOCK_W    = 32;
    localparam int unsigned NUM_BLOCKS = 8;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWriteback = 2'd1,
        StAllocate  = 2'd2,
        StUpdate    = 2'd3
    } state_e;

    function automatic logic [7:0] sel_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFFSET_W-1:0] off);
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_direct_if.sv
// CPU-side and memory-side signals of the data cache; master is the CPU/memory environment.
interface dcache_direct_if;
    import dcache_direct_pkg::*;

    logic                         read;
    logic                         write;
    logic [7:0]                   address;
    logic [7:0]                   writedata;
    logic [7:0]                   readdata;
    logic                         busywait;
    logic                         mem_read;
    logic                         mem_write;
    logic [TAG_W+INDEX_W-1:0]     mem_address;
    logic [BLOCK_W-1:0]           mem_writedata;
    logic [BLOCK_W-1:0]           mem_readdata;
    logic                         mem_busywait;

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

endinterface

// File: rtl/dcache_direct_ctrl.sv
// Miss-handling FSM: writeback of a dirty victim, block fetch, then array update.
module dcache_direct_ctrl
    import dcache_direct_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hit,
    input  logic   dirty,
    input  logic   request,
    input  logic   mem_busywait,
    output state_e state,
    output logic   mem_read,
    output logic   mem_write,
    output logic   busywait
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (request && !hit) begin
                        if (dirty) begin
                            state     <= StWriteback;
                            mem_write <= 1'b1;
                        end else begin
                            state     <= StAllocate;
                            mem_read  <= 1'b1;
                        end
                    end
                end
                StWriteback: begin
                    if (!mem_busywait) begin
                        state     <= StAllocate;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                    end
                end
                StAllocate: begin
                    if (!mem_busywait) begin
                        state    <= StUpdate;
                        mem_read <= 1'b0;
                    end
                end
                StUpdate: state <= StIdle;
                default:  state <= StIdle;
            endcase
        end
    end

    // A miss stalls in the very cycle it is detected, before the FSM leaves idle.
    assign busywait = (state != StIdle) || (request && !hit);

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped write-back, write-allocate data cache: 8 blocks of 4 bytes.
module dcache_direct
    import dcache_direct_pkg::*;
(
    input logic            CLK,
    input logic            RESET,
    dcache_direct_if.slave bus
);

    logic [BLOCK_W-1:0]  data_q [NUM_BLOCKS];
    logic [TAG_W-1:0]    tag_q  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [7:0]          readdata_q;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic                hit;
    logic                request;
    logic                wr_hit;
    logic                rd_hit;
    logic [7:0]          cur_byte;
    state_e              state;

    assign tag      = bus.address[7:5];
    assign index    = bus.address[4:2];
    assign offset   = bus.address[1:0];
    assign hit      = valid_q[index] && (tag_q[index] == tag);
    assign request  = bus.read || bus.write;
    assign wr_hit   = (state == StIdle) && bus.write && hit;
    assign rd_hit   = (state == StIdle) && bus.read && !bus.write && hit;
    assign cur_byte = sel_byte(data_q[index], offset);

    dcache_direct_ctrl u_ctrl (
        .clk          (CLK),
        .rst          (RESET),
        .hit          (hit),
        .dirty        (dirty_q[index]),
        .request      (request),
        .mem_busywait (bus.mem_busywait),
        .state        (state),
        .mem_read     (bus.mem_read),
        .mem_write    (bus.mem_write),
        .busywait     (bus.busywait)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            readdata_q <= '0;
        end else begin
            if (wr_hit) begin
                dirty_q[index] <= 1'b1;
            end else if (state == StUpdate) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
            if (rd_hit) begin
                readdata_q <= cur_byte;
            end
        end
    end

    // Data and tags are left untouched by reset; only valid/dirty gate their use.
    always_ff @(posedge CLK) begin
        if (wr_hit) begin
            data_q[index][{offset, 3'b000} +: 8] <= bus.writedata;
        end else if (state == StUpdate) begin
            data_q[index] <= bus.mem_readdata;
            tag_q[index]  <= tag;
        end
    end

    assign bus.readdata      = RESET ? 8'h00 : (rd_hit ? cur_byte : readdata_q);
    assign bus.mem_address   = (state == StWriteback) ? {tag_q[index], index} : {tag, index};
    assign bus.mem_writedata = data_q[index];

endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench for dcache_direct with a simple fixed-latency block memory model.
module tb_dcache_direct;
    import dcache_direct_pkg::*;

    localparam int MEM_BUSY = 5;
    localparam int TIMEOUT  = 100;

    typedef struct packed {
        logic       chk;
        logic [7:0] data;
        logic [7:0] id;
    } cpu_exp_t;

    typedef struct packed {
        logic        is_write;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_direct_if bus ();

    dcache_direct dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    cpu_exp_t    cpu_q[$];
    mem_exp_t    mem_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          acc_id   = 0;
    logic [31:0] mem_model [64];
    logic        mem_active;
    int          mem_cnt;
    logic [5:0]  mem_addr_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // CPU-side monitor: an access completes on any cycle with a request and no stall.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.read || bus.write) && !bus.busywait) begin
                if (cpu_q.size() == 0) begin
                    flag("cpu_unexpected_completion");
                end else begin
                    e = cpu_q.pop_front();
                    if (e.chk) check($sformatf("readdata_%0d", e.id), {24'h0, bus.readdata},
                                     {24'h0, e.data});
                end
            end
        end
    end

    // Memory model and memory-side monitor: MEM_BUSY busy cycles then one done cycle.
    initial begin
        mem_exp_t m;
        for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
        mem_model[6'h01] = 32'hDDCCBBAA;
        mem_model[6'h09] = 32'h44332211;
        bus.mem_busywait = 1'b1;
        bus.mem_readdata = 32'h0;
        mem_active       = 1'b0;
        mem_cnt          = 0;
        mem_addr_lat     = 6'h0;
        forever begin
            @(negedge clk);
            bus.mem_busywait = 1'b1;
            if (rst) begin
                mem_active = 1'b0;
            end else begin
                if (mem_active) begin
                    mem_cnt++;
                end else if (bus.mem_read || bus.mem_write) begin
                    check("mem_rd_wr_exclusive", {31'h0, bus.mem_read & bus.mem_write}, 32'h0);
                    mem_active   = 1'b1;
                    mem_cnt      = 0;
                    mem_addr_lat = bus.mem_address;
                    if (mem_q.size() == 0) begin
                        flag("mem_unexpected_request");
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_is_write", {31'h0, bus.mem_write}, {31'h0, m.is_write});
                        check("mem_address", {26'h0, bus.mem_address}, {26'h0, m.addr});
                        if (m.is_write) check("mem_writedata", bus.mem_writedata, m.wdata);
                    end
                end
                if (mem_active && mem_cnt == MEM_BUSY) begin
                    bus.mem_busywait = 1'b0;
                    if (bus.mem_write) mem_model[mem_addr_lat] = bus.mem_writedata;
                    else bus.mem_readdata = mem_model[mem_addr_lat];
                    mem_active = 1'b0;
                end
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input int exp_stall);
        int stall = 0;
        bit done  = 1'b0;
        @(posedge clk);
        #1;
        bus.read      = rd;
        bus.write     = wr;
        bus.address   = addr;
        bus.writedata = wdata;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (!bus.busywait) begin
                done = 1'b1;
                break;
            end
            stall++;
        end
        if (!done) flag($sformatf("timeout_access_%0d addr=%h", acc_id, addr));
        else check($sformatf("stall_cycles_%0d", acc_id), stall, exp_stall);
        acc_id++;
        @(posedge clk);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] exp, input int exp_stall);
        cpu_q.push_back('{chk: 1'b1, data: exp, id: 8'(acc_id)});
        access(1'b1, 1'b0, addr, 8'h00, exp_stall);
    endtask

    task automatic do_write(input logic rd, input logic [7:0] addr, input logic [7:0] data,
                            input int exp_stall);
        cpu_q.push_back('{chk: 1'b0, data: 8'h00, id: 8'(acc_id)});
        access(rd, 1'b1, addr, data, exp_stall);
    endtask

    initial begin
        bit seen = 1'b0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = 8'h00;
        bus.writedata = 8'h00;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busywait", {31'h0, bus.busywait}, 32'h0);
        check("reset_mem_read", {31'h0, bus.mem_read}, 32'h0);
        check("reset_mem_write", {31'h0, bus.mem_write}, 32'h0);
        check("reset_readdata", {24'h0, bus.readdata}, 32'h0);

        // Clean miss: 1 detect + 6 allocate + 1 update.
        mem_q.push_back('{is_write: 1'b0, addr: 6'h01, wdata: 32'h0});
        do_read(8'h04, 8'hAA, 8);
        do_read(8'h07, 8'hDD, 0);
        do_write(1'b0, 8'h05, 8'h5A, 0);
        do_read(8'h05, 8'h5A, 0);

        // Dirty miss: 1 detect + 6 writeback + 6 allocate + 1 update.
        mem_q.push_back('{is_write: 1'b1, addr: 6'h01, wdata: 32'hDDCC5AAA});
        mem_q.push_back('{is_write: 1'b0, addr: 6'h09, wdata: 32'h0});
        do_read(8'h24, 8'h11, 14);

        do_write(1'b1, 8'h24, 8'h77, 0);
        do_read(8'h24, 8'h77, 0);

        mem_q.push_back('{is_write: 1'b1, addr: 6'h09, wdata: 32'h44332277});
        mem_q.push_back('{is_write: 1'b0, addr: 6'h01, wdata: 32'h0});
        do_read(8'h05, 8'h5A, 14);

        // Reset in the middle of an allocate.
        mem_q.push_back('{is_write: 1'b0, addr: 6'h03, wdata: 32'h0});
        @(posedge clk);
        #1;
        bus.read    = 1'b1;
        bus.address = 8'h0C;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (bus.mem_read) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag("timeout_abort_mem_read");
        @(posedge clk);
        #1;
        rst      = 1'b1;
        bus.read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_mem_read", {31'h0, bus.mem_read}, 32'h0);
        check("abort_mem_write", {31'h0, bus.mem_write}, 32'h0);
        check("abort_busywait", {31'h0, bus.busywait}, 32'h0);
        check("abort_readdata", {24'h0, bus.readdata}, 32'h0);
        check("abort_state", {30'h0, dut.u_ctrl.state}, {30'h0, StIdle});
        check("abort_valid", {24'h0, dut.valid_q}, 32'h0);

        mem_q.push_back('{is_write: 1'b0, addr: 6'h01, wdata: 32'h0});
        do_read(8'h04, 8'hAA, 8);
        do_read(8'h06, 8'hCC, 0);

        repeat (3) @(posedge clk);
        #1;
        check("cpu_queue_empty", cpu_q.size(), 32'h0);
        check("mem_queue_empty", mem_q.size(), 32'h0);
        check("mem_block9_written_back", mem_model[6'h09], 32'h44332277);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-back, write-allocate data cache sitting directly downstream of the CPU ALU.
- The ALU RESULT drives the cache address for lw/sw/lwi/swi; the register file OUT1 supplies the store data.
- It fronts the 32-bit-block data memory and stalls the CPU via busywait on misses.
- Geometry: 8 blocks x 4 bytes; address split tag[7:5], index[4:2], offset[1:0].

Parameters:
- None; geometry is fixed by the 8-bit address. The localparams listed under Decomposition are not overridable.

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RESET  input  1  synchronous, active-high reset
read  input  1  CPU load request
write  input  1  CPU store request
address  input  8  byte address (from ALU RESULT)
writedata  input  8  store byte
readdata  output  8  load byte
busywait  output  1  CPU stall
mem_read  output  1  memory block read request
mem_write  output  1  memory block write request
mem_address  output  6  block address {tag,index}
mem_writedata  output  32  evicted block; byte0 = bits[7:0]
mem_readdata  input  32  fetched block
mem_busywait  input  1  memory busy; low for one cycle marks completion

Behaviour:
- Reset: sampled only on the CLK edge.
  - Clears all valid and dirty bits and returns the FSM to IDLE.
  - Data and tag arrays are not cleared.
  - Output values during and after reset: mem_read=0, mem_write=0, busywait=0, readdata=0.
  - Reset during WRITEBACK/ALLOCATE aborts the memory transaction; the dirty block is discarded by design.
- Hit definition: hit = valid[index] && tag_array[index]==address[7:5]; evaluated combinationally.
- busywait is combinational. It is high when:
  - (read|write) is asserted and there is no hit in IDLE, or
  - the FSM is in any state other than IDLE.
- Read hit:
  - readdata = the selected byte, combinationally; busywait stays 0.
  - Zero-stall: the CPU latches readdata at the next edge.
- Write hit:
  - The byte is written and dirty[index] set at the next CLK edge; busywait stays 0.
- read && write together: the write takes priority; readdata is don't-care.
- Request signals must stay stable while busywait=1; the cache does not latch them.
- When neither read nor write is asserted: no state change, busywait=0, readdata holds the last value.
- FSM states:
  - IDLE:
    - On a miss with dirty[index]=1, go to WRITEBACK.
    - On a miss with dirty[index]=0, go to ALLOCATE.
    - Otherwise stay in IDLE.
  - WRITEBACK:
    - Drives mem_write=1, mem_address={tag_array[index],index}, mem_writedata=data_array[index].
    - When mem_busywait==0 (sampled at the edge), go to ALLOCATE.
  - ALLOCATE:
    - Drives mem_read=1, mem_address={address[7:5],index}.
    - When mem_busywait==0, go to UPDATE.
  - UPDATE:
    - mem_read and mem_write are both 0.
    - At the edge: data_array[index]=mem_readdata, tag=address[7:5], valid=1, dirty=0; go to IDLE.
    - The retried access then hits in IDLE in the following cycle (write hit sets dirty).
- mem_read and mem_write are never high together; both are 0 in IDLE and UPDATE.
- Miss latency: the clean miss cost below excludes the final hit cycle; a dirty miss adds the writeback duration.
  - Clean miss: 1 (IDLE detect) + memory read cycles + 1 (UPDATE).
- Byte select: byte k = block bits [8k+7:8k], with k = offset.
- readdata is driven only by data_array; there is no bypass from mem_readdata.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2, UPDATE=2'd3.
  - Field widths: TAG_W=3, INDEX_W=3, OFFSET_W=2, BLOCK_W=32, NUM_BLOCKS=8.
- One natural sub-module: dcache_ctrl, the FSM.
  - Inputs: hit, dirty, request, mem_busywait.
  - Outputs: state, mem_read, mem_write, busywait.
- Arrays and byte muxing stay in dcache_direct.

Test Plan:
- RESET=1 for 1 cycle, then read address 8'h04 → busywait=1 and FSM enters ALLOCATE with mem_address=6'h01. Memory returns 32'hDDCCBBAA after 5 busy cycles → UPDATE, then readdata=8'hAA, busywait=0.
- After the previous scenario, read 8'h07 → hit, no stall, readdata=8'hDD the same cycle; mem_read stays 0.
- Write 8'h05 data 8'h5A (hit) → no stall, dirty[1]=1; a subsequent read of 8'h05 returns 8'h5A.
- Read 8'h24 (same index 1, tag 1, dirty) → WRITEBACK with mem_address=6'h01 and mem_writedata=32'hDDCC5AAA, then ALLOCATE with mem_address=6'h09, then UPDATE, then hit; dirty[1]=0.
- read=1 and write=1 at 8'h24, data 8'h77 → treated as a write; a later read of 8'h24 returns 8'h77.
- Assert RESET while in ALLOCATE → the next cycle has mem_read=0, busywait=0, state IDLE, valid cleared; re-reading 8'h04 misses again.
